// File: rtl/fpga_ctrl_pkg.sv
// Shared types for the FPGA reset sequencer / exit monitor.
// Holds the FSM state encoding and the passing exit code.
package fpga_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RUN       = 2'd2,
    EXITED    = 2'd3
  } state_e;

  localparam logic [31:0] EXIT_PASS_CODE = 32'h0;

endpackage

// File: rtl/fpga_sat_counter.sv
// Saturating counter 0..MAX-1 with sync clear (priority) and enable.
// Ports: clk_i, rst_i (async high), clr_i, en_i, done_o (count == MAX-1).
module fpga_sat_counter #(
  parameter int unsigned MAX = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0] TERM = W'(MAX - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TERM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == TERM);

endmodule

// File: rtl/fpga_rst_exit_ctrl.sv
// Board reset sequencer + MCU exit-status monitor for the x_heep FPGA top.
// Ports: clk_i, rst_i (async high), pll_locked_i, exit_valid_i,
//   exit_value_i[31:0] in; sys_rst_no, rst_led_o, clk_led_o, status_led_o,
//   exit_value_o, exit_done_o, exit_code_o[31:0] out (all registered).
// Option: FPGA_AUTO_RESTART_EN re-stretches reset RESTART_DELAY_CYCLES
//   after an exit, keeping the last exit code visible.
module fpga_rst_exit_ctrl
  import fpga_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_FILTER_CYCLES   = 16,
  parameter int unsigned RST_STRETCH_CYCLES   = 1024,
  parameter int unsigned CLK_LED_COUNT_LENGTH = 27,
  parameter int unsigned FAIL_BLINK_BIT       = 22,
  parameter int unsigned RESTART_DELAY_CYCLES = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pll_locked_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        sys_rst_no,
  output logic        rst_led_o,
  output logic        clk_led_o,
  output logic        status_led_o,
  output logic        exit_value_o,
  output logic        exit_done_o,
  output logic [31:0] exit_code_o
);

  localparam int unsigned HBW = CLK_LED_COUNT_LENGTH;

  state_e state_q, state_d;

  logic           srn_q, srn_d;
  logic           stat_q, stat_d;
  logic           done_q, done_d;
  logic [31:0]    code_q, code_d;
  logic [HBW-1:0] hb_q, hb_d;

  logic lock_done, str_done;
  logic in_wait, in_str;

  assign in_wait = (state_q == WAIT_LOCK);
  assign in_str  = (state_q == STRETCH);

  // Clearing on terminal count makes the counter restart from 0
  // on the same edge the FSM leaves the state.
  fpga_sat_counter #(
    .MAX (LOCK_FILTER_CYCLES)
  ) u_lock_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (!in_wait || !pll_locked_i || lock_done),
    .en_i   (in_wait && pll_locked_i),
    .done_o (lock_done)
  );

  fpga_sat_counter #(
    .MAX (RST_STRETCH_CYCLES)
  ) u_str_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (!in_str || !pll_locked_i || str_done),
    .en_i   (in_str),
    .done_o (str_done)
  );

`ifdef FPGA_AUTO_RESTART_EN
  logic rs_done;
  logic in_exit;

  assign in_exit = (state_q == EXITED);

  fpga_sat_counter #(
    .MAX (RESTART_DELAY_CYCLES)
  ) u_rs_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (!in_exit || !pll_locked_i || rs_done),
    .en_i   (in_exit),
    .done_o (rs_done)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^RESTART_DELAY_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    code_d  = code_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (pll_locked_i && lock_done) begin
          state_d = STRETCH;
        end
      end
      STRETCH: begin
        if (!pll_locked_i) begin
          state_d = WAIT_LOCK;
        end else if (str_done) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // lock loss beats a same-cycle exit
        if (!pll_locked_i) begin
          state_d = WAIT_LOCK;
          done_d  = 1'b0;
          code_d  = '0;
        end else if (exit_valid_i) begin
          state_d = EXITED;
          done_d  = 1'b1;
          code_d  = exit_value_i;
        end
      end
      EXITED: begin
        if (!pll_locked_i) begin
          state_d = WAIT_LOCK;
          done_d  = 1'b0;
          code_d  = '0;
        end
`ifdef FPGA_AUTO_RESTART_EN
        else if (rs_done) begin
          state_d = STRETCH;
          done_d  = 1'b0;
        end
`endif
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Outputs are computed from next-state values so every output
  // register changes on the same edge as the FSM decision.
  always_comb begin
    hb_d   = hb_q + 1'b1;
    srn_d  = (state_d == RUN) || (state_d == EXITED);
    stat_d = (state_d == EXITED) &&
             ((code_d == EXIT_PASS_CODE) || hb_d[FAIL_BLINK_BIT]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WAIT_LOCK;
      srn_q   <= 1'b0;
      stat_q  <= 1'b0;
      done_q  <= 1'b0;
      code_q  <= '0;
      hb_q    <= '0;
    end else begin
      state_q <= state_d;
      srn_q   <= srn_d;
      stat_q  <= stat_d;
      done_q  <= done_d;
      code_q  <= code_d;
      hb_q    <= hb_d;
    end
  end

  assign sys_rst_no   = srn_q;
  assign rst_led_o    = srn_q;
  assign clk_led_o    = hb_q[HBW-1];
  assign status_led_o = stat_q;
  assign exit_value_o = code_q[0];
  assign exit_done_o  = done_q;
  assign exit_code_o  = code_q;

endmodule

// File: tb/tb_fpga_rst_exit_ctrl.sv
// Bench for fpga_rst_exit_ctrl: behavioural model feeds a scoreboard,
// plus explicit latency checks on the reset sequence.
module tb_fpga_rst_exit_ctrl;

  localparam int LF  = 4;
  localparam int RS  = 8;
  localparam int HBW = 6;
  localparam int FB  = 2;
  localparam int RD  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        lock;
  logic        ev;
  logic [31:0] val;
  logic        srn, rled, cled, sled, evo, edone;
  logic [31:0] ecode;

  fpga_rst_exit_ctrl #(
    .LOCK_FILTER_CYCLES   (LF),
    .RST_STRETCH_CYCLES   (RS),
    .CLK_LED_COUNT_LENGTH (HBW),
    .FAIL_BLINK_BIT       (FB),
    .RESTART_DELAY_CYCLES (RD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pll_locked_i (lock),
    .exit_valid_i (ev),
    .exit_value_i (val),
    .sys_rst_no   (srn),
    .rst_led_o    (rled),
    .clk_led_o    (cled),
    .status_led_o (sled),
    .exit_value_o (evo),
    .exit_done_o  (edone),
    .exit_code_o  (ecode)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [37:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  int             m_st, m_lc, m_sc, m_rc;
  logic [HBW-1:0] m_hb;
  logic           m_done, m_srn, m_stat;
  logic [31:0]    m_code;

  task automatic chk(string tag, logic [37:0] obs, logic [37:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] m_outs();
    return {m_srn, m_srn, m_hb[HBW-1], m_stat,
            m_code[0], m_done, m_code};
  endfunction

  function automatic logic [37:0] dut_outs();
    return {srn, rled, cled, sled, evo, edone, ecode};
  endfunction

  task automatic model_reset();
    m_st = 0; m_lc = 0; m_sc = 0; m_rc = 0;
    m_hb = '0; m_done = 0; m_srn = 0; m_stat = 0;
    m_code = '0;
  endtask

  task automatic model_step();
    int ns;
    ns = m_st;
    if (rst) begin
      model_reset();
    end else begin
      case (m_st)
        0: begin
          if (!lock) m_lc = 0;
          else if (m_lc == LF - 1) begin ns = 1; m_lc = 0; end
          else m_lc++;
        end
        1: begin
          if (!lock) begin ns = 0; m_sc = 0; end
          else if (m_sc == RS - 1) begin ns = 2; m_sc = 0; end
          else m_sc++;
        end
        2: begin
          if (!lock) begin ns = 0; m_done = 0; m_code = '0; end
          else if (ev) begin ns = 3; m_done = 1; m_code = val; end
        end
        default: begin
          if (!lock) begin
            ns = 0; m_done = 0; m_code = '0; m_rc = 0;
          end
`ifdef FPGA_AUTO_RESTART_EN
          else if (m_rc == RD - 1) begin
            ns = 1; m_rc = 0; m_done = 0;
          end else m_rc++;
`endif
        end
      endcase
      m_hb++;
      m_st   = ns;
      m_srn  = (ns >= 2);
      m_stat = (ns == 3) && ((m_code == 32'h0) || m_hb[FB]);
    end
  endtask

  task automatic push_exp(string tag);
    sb_t e;
    e.tag = tag;
    e.exp = m_outs();
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    sb_t e;
    e = sb.pop_front();
    chk(e.tag, dut_outs(), e.exp);
  endtask

  task automatic step(string tag);
    model_step();
    push_exp(tag);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  task automatic now_cmp(string tag);
    push_exp(tag);
    pop_cmp();
  endtask

  task automatic rise_lat(string tag, int want);
    int n;
    n = 0;
    do begin
      step(tag);
      n++;
    end while (!srn && n < 40);
    chk({tag, "_lat"}, 38'(n), 38'(want));
  endtask

  task automatic async_rst(string tag);
    rst = 1'b1;
    #1;
    model_reset();
    now_cmp(tag);
    step({tag, "_hold"});
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lock = 1'b0; ev = 1'b0; val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    now_cmp("reset");

    rst = 1'b0; lock = 1'b1;
    rise_lat("boot", LF + RS);
    repeat (3) step("run_idle");

    async_rst("rst_run");
    lock = 1'b1;
    repeat (3) step("pre_glitch");
    lock = 1'b0;
    step("glitch");
    lock = 1'b1;
    rise_lat("glitch", LF + RS);

    ev = 1'b1; val = 32'h0;
    step("exit_pass");
    ev = 1'b0;
    repeat (6) step("pass_hold");
    ev = 1'b1; val = 32'h5;
    step("exit_ignored");
    ev = 1'b0;
    repeat (4) step("pass_after");

    lock = 1'b0;
    step("loss_exited");
    lock = 1'b1;
    rise_lat("relock1", LF + RS);

    ev = 1'b1; val = 32'h3;
    step("exit_fail");
    ev = 1'b0;
    repeat (14) step("fail_blink");

    lock = 1'b0;
    step("loss_fail");
    lock = 1'b1;
    rise_lat("relock2", LF + RS);

    lock = 1'b0; ev = 1'b1; val = 32'h9;
    step("loss_vs_exit");
    ev = 1'b0; lock = 1'b1;
    repeat (6) step("restretch");
    async_rst("rst_stretch");
    rise_lat("relock3", LF + RS);

`ifdef FPGA_AUTO_RESTART_EN
    begin
      int n;
      ev = 1'b1; val = 32'h0;
      step("ar_exit");
      ev = 1'b0;
      n = 0;
      do begin step("ar_wait"); n++; end while (srn && n < 40);
      chk("ar_delay", 38'(n), 38'(RD));
      n = 0;
      do begin step("ar_low"); n++; end while (!srn && n < 40);
      chk("ar_low_len", 38'(n), 38'(RS));
      ev = 1'b1; val = 32'h6;
      step("ar_exit2");
      ev = 1'b0;
      repeat (24) step("ar_keep");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpga_rst_exit_ctrl.md
Name: fpga_rst_exit_ctrl

Overview:
Board-level reset sequencer and exit-status monitor for the FPGA top of x_heep_system.
- Reset: qualifies the clock-wizard lock, stretches the system reset, then releases an active-low reset to the MCU.
- Exit: latches the MCU exit code and drives heartbeat, reset and pass/fail status LEDs.
- Placement: sits between the clock wizard / board button and x_heep_system rst_ni.

Parameters:
- LOCK_FILTER_CYCLES, 16: consecutive locked cycles required before the lock counts as stable (≥1).
- RST_STRETCH_CYCLES, 1024: cycles sys_rst_no is held low after a stable lock (≥1).
- CLK_LED_COUNT_LENGTH, 27: heartbeat counter width.
- FAIL_BLINK_BIT, 22: heartbeat bit used for the fail blink (< CLK_LED_COUNT_LENGTH).
- RESTART_DELAY_CYCLES, 4096: delay before automatic restart (optional feature only).

Ports:
- clk_i  in  1  clock from the clock wizard.
- rst_i  in  1  asynchronous active-high reset, board button after polarity fix.
- pll_locked_i  in  1  clock-wizard locked.
- exit_valid_i  in  1  MCU exit_valid_o.
- exit_value_i  in  32  MCU exit_value_o.
- sys_rst_no  out  1  active-low reset to x_heep_system; registered output.
- rst_led_o  out  1  equals sys_rst_no.
- clk_led_o  out  1  heartbeat counter MSB.
- status_led_o  out  1  exit status indication.
- exit_value_o  out  1  bit 0 of the latched exit code.
- exit_done_o  out  1  an exit code has been latched.
- exit_code_o  out  32  latched exit code.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (clk_i, rst_i). While rst_i is high:
  - state=WAIT_LOCK; all counters 0.
  - sys_rst_no=0, rst_led_o=0, clk_led_o=0, status_led_o=0.
  - exit_value_o=0, exit_done_o=0, exit_code_o=0.
- FSM states: WAIT_LOCK, STRETCH, RUN, EXITED. All outputs are registered and update on the edge after the decision.
- WAIT_LOCK:
  - sys_rst_no=0.
  - lock_cnt increments while pll_locked_i=1 and clears to 0 on any pll_locked_i=0.
  - When lock_cnt reaches LOCK_FILTER_CYCLES-1 with pll_locked_i=1, go to STRETCH and clear lock_cnt.
- STRETCH:
  - sys_rst_no=0; stretch_cnt increments each cycle.
  - When stretch_cnt reaches RST_STRETCH_CYCLES-1, go to RUN; sys_rst_no=1 from the next edge.
  - pll_locked_i=0 → WAIT_LOCK, stretch_cnt cleared.
- RUN:
  - sys_rst_no=1.
  - exit_valid_i=1 → latch exit_value_i into exit_code_o, set exit_done_o=1, go to EXITED.
- EXITED:
  - sys_rst_no stays 1; exit_code_o is frozen.
  - Further exit_valid_i pulses are ignored.
- Lock loss in RUN or EXITED:
  - Go to WAIT_LOCK; sys_rst_no=0 on the next edge.
  - exit_done_o and exit_code_o are cleared on that same edge.
- Simultaneous exit_valid_i=1 and pll_locked_i=0 in RUN: lock loss wins and the code is not latched.
- exit_valid_i is ignored in WAIT_LOCK and STRETCH.
- Latency: lock is stable at time T → sys_rst_no rises exactly LOCK_FILTER_CYCLES+RST_STRETCH_CYCLES edges after the first locked sample.
- Heartbeat:
  - CLK_LED_COUNT_LENGTH-bit counter increments every cycle outside reset and wraps modulo 2^N.
  - clk_led_o = counter MSB.
- status_led_o:
  - 0 in WAIT_LOCK, STRETCH and RUN.
  - EXITED with exit_code_o==0 → 1 (pass).
  - EXITED with exit_code_o≠0 → heartbeat[FAIL_BLINK_BIT] (fail blink).
- exit_value_o = exit_code_o[0].
- Counter widths: $clog2 of the respective max, minimum 1 bit; they never exceed their terminal value.
- rst_i asserted mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro: FPGA_AUTO_RESTART_EN.
- Defined:
  - EXITED runs restart_cnt; at RESTART_DELAY_CYCLES-1 go to STRETCH (sys_rst_no=0) and clear exit_done_o.
  - exit_code_o is kept until the next exit latch, so the last result stays readable on the LEDs during the stretch.
  - Lock loss still takes priority.
- Undefined: EXITED is terminal until rst_i or lock loss; RESTART_DELAY_CYCLES is unused.

Decomposition:
- Package fpga_ctrl_pkg:
  - state enum typedef (2-bit, encodings WAIT_LOCK=0, STRETCH=1, RUN=2, EXITED=3).
  - EXIT_PASS_CODE=32'h0.
- Sub-module fpga_sat_counter:
  - Parameterized MAX, with clr and en inputs and a done output.
  - Instantiated for the lock filter, the reset stretch and the restart delay.
- The FSM and LED logic stay in the top.

Test Plan:
- Bench parameters: LOCK_FILTER_CYCLES=4, RST_STRETCH_CYCLES=8, CLK_LED_COUNT_LENGTH=6, FAIL_BLINK_BIT=2.
- Release rst_i with pll_locked_i=1 → sys_rst_no rises exactly 12 edges later; all outputs are 0 before that.
- Lock glitch (low 1 cycle) after 3 locked cycles, then stable → stretch begins 4 locked cycles after the glitch; sys_rst_no rises 12 edges after the glitch ends.
- In RUN, exit_valid_i=1 with exit_value_i=0 → exit_done_o=1, exit_code_o=0, status_led_o=1 constant. A later exit_valid_i with 5 is ignored.
- In RUN, exit_valid_i=1 with exit_value_i=32'h3 → exit_value_o=1, and status_led_o toggles every 4 cycles in phase with heartbeat bit 2.
- pll_locked_i drops in the same cycle as exit_valid_i → WAIT_LOCK, sys_rst_no=0 next edge, exit_done_o=0; rst_i pulse mid-STRETCH → immediate reset values.
- With FPGA_AUTO_RESTART_EN and RESTART_DELAY_CYCLES=16: exit 0 → 16 cycles later sys_rst_no=0 for 8 cycles, then 1; exit_code_o is retained throughout.
